// File: rtl/seg7_pkg.sv
// Shared segment patterns and digit-code type for the multiplexed 7-segment
// scan driver.
package seg7_pkg;

    typedef logic [3:0] digit_code_t;

    // Patterns are {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;

    localparam int MAX_DIGITS = 8;

    // A single-digit display still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_7seg_scan_driver_if.sv
// Host-side bus of the scan driver: digit load port plus the registered
// display outputs.
interface bcd_7seg_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   data;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     an;
    logic                    pending;
    logic                    frame_tick;

    modport master (
        output load, data, dp_in, blank_lz,
        input  seg, dp, an, pending, frame_tick
    );

    modport slave (
        input  load, data, dp_in, blank_lz,
        output seg, dp, an, pending, frame_tick
    );
endinterface

// File: rtl/bcd_7seg_scan_driver_seg7_decode.sv
// Combinational digit-code to segment decoder. Define SEG_HEX_EN to show
// codes 10-15 as A,b,C,d,E,F; otherwise those codes blank the digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  digit_code_t code,
    output logic [6:0]  seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
`ifdef SEG_HEX_EN
            4'd10:   seg = SEG_A;
            4'd11:   seg = SEG_B;
            4'd12:   seg = SEG_C;
            4'd13:   seg = SEG_D;
            4'd14:   seg = SEG_E;
            4'd15:   seg = SEG_F;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: seg = SEG_BLANK;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed BCD 7-segment driver with double-buffered digit data that
// swaps only at frame boundaries. SEG_HEX_EN (see seg7_decode) enables hex glyphs.
module bcd_7seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 1000
)(
    input  logic                   clk,
    input  logic                   rst,
    bcd_7seg_scan_driver_if.slave  bus
);

    localparam int PCNT_W = $clog2(PRESCALE);
    localparam int IDX_W  = idx_width(N_DIGITS);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    logic [PCNT_W-1:0]     pcnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [4*N_DIGITS-1:0] active_data_reg;
    logic [N_DIGITS-1:0]   active_dp_reg;
    logic [4*N_DIGITS-1:0] pend_data_reg;
    logic [N_DIGITS-1:0]   pend_dp_reg;
    logic                  pending_reg;
    logic                  frame_tick_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic [N_DIGITS-1:0]   an_reg;

    logic                  slot_end;
    logic                  frame_end;
    digit_code_t           digits [N_DIGITS];
    logic [N_DIGITS-1:0]   digit_nz;
    logic [N_DIGITS-1:0]   zero_above;
    logic                  zero_run;
    digit_code_t           sel_code;
    logic [6:0]            dec_seg;
    logic                  blank_sel;
    logic [6:0]            seg_next;
    logic [N_DIGITS-1:0]   an_next;

    assign slot_end  = (pcnt_reg == PCNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg <= '0;
            idx_reg  <= '0;
        end else if (slot_end) begin
            pcnt_reg <= '0;
            idx_reg  <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_ONE;
        end else begin
            pcnt_reg <= pcnt_reg + PCNT_ONE;
        end
    end

    // A load landing exactly on the frame boundary bypasses the pending buffer
    // so the new value is never held back a whole extra frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_data_reg <= '0;
            active_dp_reg   <= '0;
            pend_data_reg   <= '0;
            pend_dp_reg     <= '0;
            pending_reg     <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_data_reg <= bus.data;
                pend_dp_reg   <= bus.dp_in;
            end
            if (bus.load && frame_end) begin
                active_data_reg <= bus.data;
                active_dp_reg   <= bus.dp_in;
                pending_reg     <= 1'b0;
            end else if (bus.load) begin
                pending_reg     <= 1'b1;
            end else if (frame_end && pending_reg) begin
                active_data_reg <= pend_data_reg;
                active_dp_reg   <= pend_dp_reg;
                pending_reg     <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign digits[gi]   = active_data_reg[4*gi +: 4];
            assign digit_nz[gi] = |active_data_reg[4*gi +: 4];
        end
    endgenerate

    // zero_above[k] is set when every active digit from the top down to k is zero.
    always_comb begin
        zero_run   = 1'b1;
        zero_above = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && !digit_nz[k];
            zero_above[k] = zero_run;
        end
    end

    assign sel_code = digits[idx_reg];

    seg7_decode u_decode (
        .code (sel_code),
        .seg  (dec_seg)
    );

    assign blank_sel = bus.blank_lz && (idx_reg != '0) && zero_above[idx_reg];
    assign seg_next  = blank_sel ? SEG_BLANK : dec_seg;

    always_comb begin
        an_next          = '0;
        an_next[idx_reg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b0;
            an_reg         <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            seg_reg        <= seg_next;
            dp_reg         <= active_dp_reg[idx_reg];
            an_reg         <= an_next;
            frame_tick_reg <= frame_end;
        end
    end

    assign bus.seg        = seg_reg;
    assign bus.dp         = dp_reg;
    assign bus.an         = an_reg;
    assign bus.pending    = pending_reg;
    assign bus.frame_tick = frame_tick_reg;

endmodule
